// File: rtl/csr_trap_seq.sv
// csr_trap_seq: trap-entry / MRET sequencer in front of the M-mode CSR file.
//
// Owns the CSR file's single write port and its read address. While idle the
// EX-stage CSR access passes straight through; on a trap or MRET the pipeline
// is stalled while the required CSRs are rewritten one per cycle, followed by
// a one-cycle PC redirect.
//
// Optional feature macro: CSR_VECTORED_EN
//   defined   -> vectored interrupt targets when mtvec[1:0] == 2'b01
//   undefined -> redirect always goes to the mtvec base
//
// Ports:
//   clk, rst (async, active-low)
//   ex_csr_we/waddr/wdata/raddr  pipeline CSR access (honoured only in IDLE)
//   trap_req, trap_cause, trap_pc, trap_tval   trap request and payload
//   mret_req                                   MRET request
//   CSR_data_read                              combinational read data from CSR file
//   CSR_write_en/write_addr/data_write/read_addr   CSR file port
//   stall                                      freeze IF/ID/EX
//   redirect_valid, redirect_pc                one-cycle PC redirect
module csr_trap_seq #(
    parameter logic [11:0] MEPC_ADDR    = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR  = 12'h342,
    parameter logic [11:0] MTVAL_ADDR   = 12'h343,
    parameter logic [11:0] MSTATUS_ADDR = 12'h300,
    parameter logic [11:0] MTVEC_ADDR   = 12'h305
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_csr_we,
    input  logic [11:0] ex_csr_waddr,
    input  logic [31:0] ex_csr_wdata,
    input  logic [11:0] ex_csr_raddr,
    input  logic        trap_req,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_tval,
    input  logic        mret_req,
    input  logic [31:0] CSR_data_read,
    output logic        CSR_write_en,
    output logic [11:0] CSR_write_addr,
    output logic [31:0] CSR_data_write,
    output logic [11:0] CSR_read_addr,
    output logic        stall,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    typedef enum logic [2:0] {
        IDLE, T_MEPC, T_MCAUSE, T_MTVAL, T_MSTATUS, T_JUMP, M_MSTATUS, M_JUMP
    } state_t;

    state_t      state;
    logic [31:0] cause_q;
    logic [31:0] pc_q;
    logic [31:0] tval_q;

    // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= M.
    function automatic logic [31:0] trap_mstatus(input logic [31:0] s);
        logic [31:0] r;
        r       = s;
        r[7]    = s[3];
        r[3]    = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    // MRET: MIE <= MPIE, MPIE <= 1, MPP <= U.
    function automatic logic [31:0] mret_mstatus(input logic [31:0] s);
        logic [31:0] r;
        r        = s;
        r[3]     = s[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b00;
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cause_q <= '0;
            pc_q    <= '0;
            tval_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (trap_req) begin
                        cause_q <= trap_cause;
                        pc_q    <= trap_pc;
                        tval_q  <= trap_tval;
                        state   <= T_MEPC;
                    end else if (mret_req) begin
                        state <= M_MSTATUS;
                    end
                end
                T_MEPC:    state <= T_MCAUSE;
                T_MCAUSE:  state <= T_MTVAL;
                T_MTVAL:   state <= T_MSTATUS;
                T_MSTATUS: state <= T_JUMP;
                T_JUMP:    state <= IDLE;
                M_MSTATUS: state <= M_JUMP;
                M_JUMP:    state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

    // The CSR read port is combinational, so the read-modify-write and the
    // redirect target are formed in the same cycle the address is presented.
    always_comb begin
        CSR_write_en   = 1'b0;
        CSR_write_addr = '0;
        CSR_data_write = '0;
        CSR_read_addr  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        stall          = (state != IDLE) | trap_req | mret_req;
        case (state)
            IDLE: begin
                // A trap or MRET accepted this cycle drops the EX-stage write.
                CSR_write_en   = ex_csr_we & ~trap_req & ~mret_req;
                CSR_write_addr = ex_csr_waddr;
                CSR_data_write = ex_csr_wdata;
                CSR_read_addr  = ex_csr_raddr;
            end
            T_MEPC: begin
                CSR_write_en   = 1'b1;
                CSR_write_addr = MEPC_ADDR;
                CSR_data_write = {pc_q[31:2], 2'b00};
            end
            T_MCAUSE: begin
                CSR_write_en   = 1'b1;
                CSR_write_addr = MCAUSE_ADDR;
                CSR_data_write = cause_q;
            end
            T_MTVAL: begin
                CSR_write_en   = 1'b1;
                CSR_write_addr = MTVAL_ADDR;
                CSR_data_write = tval_q;
            end
            T_MSTATUS: begin
                CSR_read_addr  = MSTATUS_ADDR;
                CSR_write_en   = 1'b1;
                CSR_write_addr = MSTATUS_ADDR;
                CSR_data_write = trap_mstatus(CSR_data_read);
            end
            T_JUMP: begin
                CSR_read_addr  = MTVEC_ADDR;
                redirect_valid = 1'b1;
                redirect_pc    = {CSR_data_read[31:2], 2'b00};
`ifdef CSR_VECTORED_EN
                // Only asynchronous interrupts are vectored.
                if (CSR_data_read[1:0] == 2'b01 && cause_q[31])
                    redirect_pc = {CSR_data_read[31:2], 2'b00} + {25'd0, cause_q[4:0], 2'b00};
`endif
            end
            M_MSTATUS: begin
                CSR_read_addr  = MSTATUS_ADDR;
                CSR_write_en   = 1'b1;
                CSR_write_addr = MSTATUS_ADDR;
                CSR_data_write = mret_mstatus(CSR_data_read);
            end
            M_JUMP: begin
                CSR_read_addr  = MEPC_ADDR;
                redirect_valid = 1'b1;
                redirect_pc    = CSR_data_read;
            end
            default: ;
        endcase
        // Reset holds every output quiet, independent of incoming requests.
        if (!rst) begin
            CSR_write_en   = 1'b0;
            CSR_write_addr = '0;
            CSR_data_write = '0;
            CSR_read_addr  = '0;
            redirect_valid = 1'b0;
            redirect_pc    = '0;
            stall          = 1'b0;
        end
    end

endmodule

// File: tb/tb_csr_trap_seq.sv
module tb_csr_trap_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_csr_we;
    logic [11:0] ex_csr_waddr;
    logic [31:0] ex_csr_wdata;
    logic [11:0] ex_csr_raddr;
    logic        trap_req;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_tval;
    logic        mret_req;
    logic [31:0] CSR_data_read;
    logic        CSR_write_en;
    logic [11:0] CSR_write_addr;
    logic [31:0] CSR_data_write;
    logic [11:0] CSR_read_addr;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int tests = 0;
    int fails = 0;

    logic [31:0] csr_mem [0:4095];

    csr_trap_seq dut (
        .clk(clk), .rst(rst_n),
        .ex_csr_we(ex_csr_we), .ex_csr_waddr(ex_csr_waddr),
        .ex_csr_wdata(ex_csr_wdata), .ex_csr_raddr(ex_csr_raddr),
        .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc),
        .trap_tval(trap_tval), .mret_req(mret_req),
        .CSR_data_read(CSR_data_read), .CSR_write_en(CSR_write_en),
        .CSR_write_addr(CSR_write_addr), .CSR_data_write(CSR_data_write),
        .CSR_read_addr(CSR_read_addr), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    // CSR register file model: one write port, combinational read.
    assign CSR_data_read = csr_mem[CSR_read_addr];
    always @(posedge clk) begin
        if (CSR_write_en) csr_mem[CSR_write_addr] <= CSR_data_write;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    logic [31:0] exp_vec;

    initial begin
        for (int i = 0; i < 4096; i++) csr_mem[i] = 32'd0;
`ifdef CSR_VECTORED_EN
        exp_vec = 32'h0000011C;
`else
        exp_vec = 32'h00000100;
`endif
        // Reset with busy inputs: every output must stay quiet.
        rst_n = 1'b0;
        ex_csr_we = 1'b1; ex_csr_waddr = 12'h340; ex_csr_wdata = 32'h12345678;
        ex_csr_raddr = 12'h305;
        trap_req = 1'b1; mret_req = 1'b1;
        trap_cause = 32'd0; trap_pc = 32'd0; trap_tval = 32'd0;
        #3;
        chk("rst_we", {31'd0, CSR_write_en}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_rv", {31'd0, redirect_valid}, 32'd0);
        chk("rst_rpc", redirect_pc, 32'd0);
        chk("rst_waddr", {20'd0, CSR_write_addr}, 32'd0);
        chk("rst_wdata", CSR_data_write, 32'd0);
        chk("rst_raddr", {20'd0, CSR_read_addr}, 32'd0);
        trap_req = 1'b0; mret_req = 1'b0; ex_csr_we = 1'b0;
        cyc();
        rst_n = 1'b1;

        // Preload mstatus and mtvec through the pass-through path.
        cyc();
        ex_csr_we = 1'b1; ex_csr_waddr = 12'h300; ex_csr_wdata = 32'h00000008;
        cyc();
        ex_csr_waddr = 12'h305; ex_csr_wdata = 32'h00000100;
        cyc();
        // Pass-through.
        ex_csr_waddr = 12'h340; ex_csr_wdata = 32'hDEADBEEF; ex_csr_raddr = 12'h305;
        #1;
        chk("pt_we", {31'd0, CSR_write_en}, 32'd1);
        chk("pt_waddr", {20'd0, CSR_write_addr}, 32'h340);
        chk("pt_wdata", CSR_data_write, 32'hDEADBEEF);
        chk("pt_raddr", {20'd0, CSR_read_addr}, 32'h305);
        chk("pt_stall", {31'd0, stall}, 32'd0);
        chk("pt_rv", {31'd0, redirect_valid}, 32'd0);

        // Trap entry with a colliding pipeline write (cycle 0).
        cyc();
        chk("pt_mem", csr_mem[12'h340], 32'hDEADBEEF);
        ex_csr_wdata = 32'h11111111;
        trap_req = 1'b1; trap_cause = 32'd2; trap_pc = 32'h80000046; trap_tval = 32'h13;
        #1;
        chk("t0_we", {31'd0, CSR_write_en}, 32'd0);
        chk("t0_stall", {31'd0, stall}, 32'd1);
        cyc();  // cycle 1
        trap_req = 1'b0; trap_cause = 32'hFFFFFFFF; trap_pc = 32'hFFFFFFFF;
        #1;
        chk("t1_we", {31'd0, CSR_write_en}, 32'd1);
        chk("t1_waddr", {20'd0, CSR_write_addr}, 32'h341);
        chk("t1_wdata", CSR_data_write, 32'h80000044);
        chk("t1_stall", {31'd0, stall}, 32'd1);
        cyc();  // cycle 2
        chk("t2_waddr", {20'd0, CSR_write_addr}, 32'h342);
        chk("t2_wdata", CSR_data_write, 32'd2);
        cyc();  // cycle 3
        chk("t3_waddr", {20'd0, CSR_write_addr}, 32'h343);
        chk("t3_wdata", CSR_data_write, 32'h13);
        chk("t3_stall", {31'd0, stall}, 32'd1);
        cyc();  // cycle 4
        chk("t4_raddr", {20'd0, CSR_read_addr}, 32'h300);
        chk("t4_wdata", CSR_data_write, 32'h00001880);
        chk("t4_rv", {31'd0, redirect_valid}, 32'd0);
        ex_csr_we = 1'b0;
        cyc();  // cycle 5
        chk("t5_rv", {31'd0, redirect_valid}, 32'd1);
        chk("t5_rpc", redirect_pc, 32'h00000100);
        chk("t5_we", {31'd0, CSR_write_en}, 32'd0);
        chk("t5_stall", {31'd0, stall}, 32'd1);
        cyc();  // cycle 6
        chk("t6_stall", {31'd0, stall}, 32'd0);
        chk("t6_rv", {31'd0, redirect_valid}, 32'd0);
        chk("t_mem340", csr_mem[12'h340], 32'hDEADBEEF);
        chk("t_mepc", csr_mem[12'h341], 32'h80000044);
        chk("t_mcause", csr_mem[12'h342], 32'd2);
        chk("t_mtval", csr_mem[12'h343], 32'h13);
        chk("t_mstatus", csr_mem[12'h300], 32'h00001880);

        // MRET.
        cyc();
        mret_req = 1'b1;
        #1;
        chk("m0_stall", {31'd0, stall}, 32'd1);
        chk("m0_we", {31'd0, CSR_write_en}, 32'd0);
        cyc();  // cycle 1
        mret_req = 1'b0;
        #1;
        chk("m1_waddr", {20'd0, CSR_write_addr}, 32'h300);
        chk("m1_wdata", CSR_data_write, 32'h00000088);
        cyc();  // cycle 2
        chk("m2_rv", {31'd0, redirect_valid}, 32'd1);
        chk("m2_rpc", redirect_pc, 32'h80000044);
        chk("m2_we", {31'd0, CSR_write_en}, 32'd0);
        cyc();  // cycle 3
        chk("m3_stall", {31'd0, stall}, 32'd0);
        chk("m3_rv", {31'd0, redirect_valid}, 32'd0);
        chk("m_mstatus", csr_mem[12'h300], 32'h00000088);

        // Vectored-mode mtvec, then trap and MRET raised together.
        ex_csr_we = 1'b1; ex_csr_waddr = 12'h305; ex_csr_wdata = 32'h00000101;
        cyc();
        ex_csr_we = 1'b0;
        trap_req = 1'b1; mret_req = 1'b1;
        trap_cause = 32'h80000007; trap_pc = 32'h00000200; trap_tval = 32'd0;
        cyc();  // cycle 1
        trap_req = 1'b0; mret_req = 1'b0;
        #1;
        chk("v1_waddr", {20'd0, CSR_write_addr}, 32'h341);
        chk("v1_wdata", CSR_data_write, 32'h00000200);
        cyc(); cyc(); cyc();  // cycle 4
        chk("v4_wdata", CSR_data_write, 32'h00001880);
        cyc();  // cycle 5
        chk("v5_rv", {31'd0, redirect_valid}, 32'd1);
        chk("v5_rpc", redirect_pc, exp_vec);
        cyc();
        chk("v_mstatus", csr_mem[12'h300], 32'h00001880);
        chk("v_mcause", csr_mem[12'h342], 32'h80000007);

        // Reset during T_MTVAL.
        trap_req = 1'b1; trap_cause = 32'd5; trap_pc = 32'h00000300; trap_tval = 32'hABC;
        cyc();  // cycle 1
        trap_req = 1'b0;
        cyc();  // cycle 2
        cyc();  // cycle 3: T_MTVAL
        rst_n = 1'b0;
        #1;
        chk("r_stall", {31'd0, stall}, 32'd0);
        chk("r_we", {31'd0, CSR_write_en}, 32'd0);
        chk("r_rv", {31'd0, redirect_valid}, 32'd0);
        cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("r_post_rv", {31'd0, redirect_valid}, 32'd0);
            chk("r_post_we", {31'd0, CSR_write_en}, 32'd0);
            cyc();
        end
        chk("r_mepc", csr_mem[12'h341], 32'h00000300);
        chk("r_mcause", csr_mem[12'h342], 32'd5);
        chk("r_mtval", csr_mem[12'h343], 32'd0);
        chk("r_mstatus", csr_mem[12'h300], 32'h00001880);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/csr_trap_seq.md
# csr_trap_seq

- Sequences trap entry and MRET return for the M-mode CSR file.
- Sits directly upstream of the CSR register file, which has one write port and one combinational read port. It owns that file's write port and read address.
- While idle it passes the EX-stage CSR instruction access straight through. On a trap or MRET it stalls the pipeline, performs the required CSR read-modify-writes one per cycle, then issues a one-cycle PC redirect.

## Interface
Parameters:
- MEPC_ADDR, 12'h341: exception PC CSR
- MCAUSE_ADDR, 12'h342: cause CSR
- MTVAL_ADDR, 12'h343: trap value CSR
- MSTATUS_ADDR, 12'h300: status CSR
- MTVEC_ADDR, 12'h305: trap vector CSR

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- ex_csr_we  in  1  pipeline CSR instruction write enable
- ex_csr_waddr  in  12  pipeline CSR write address
- ex_csr_wdata  in  32  pipeline CSR write data
- ex_csr_raddr  in  12  pipeline CSR read address
- trap_req  in  1  exception/interrupt request (level, sampled in IDLE)
- trap_cause  in  32  mcause value; bit 31 = interrupt
- trap_pc  in  32  PC of trapping instruction
- trap_tval  in  32  mtval value
- mret_req  in  1  MRET request (sampled in IDLE)
- CSR_data_read  in  32  read data returned from CSR file
- CSR_write_en  out  1  to CSR file
- CSR_write_addr  out  12  to CSR file
- CSR_data_write  out  32  to CSR file
- CSR_read_addr  out  12  to CSR file
- stall  out  1  freeze IF/ID/EX
- redirect_valid  out  1  one-cycle PC redirect strobe
- redirect_pc  out  32  redirect target

## Operation
States: IDLE, T_MEPC, T_MCAUSE, T_MTVAL, T_MSTATUS, T_JUMP, M_MSTATUS, M_JUMP.

**IDLE**
- CSR outputs mirror the ex_csr_* inputs combinationally.
- If trap_req=1: latch cause/pc/tval, suppress CSR_write_en for that cycle (the trapping instruction's write is dropped), go to T_MEPC.
- Else if mret_req=1: suppress CSR_write_en, go to M_MSTATUS.
- trap_req wins over simultaneous mret_req.

**Trap sequence** (each state writes one CSR, then advances)
- T_MEPC: write MEPC = pc & ~3.
- T_MCAUSE: write MCAUSE = cause.
- T_MTVAL: write MTVAL = tval.
- T_MSTATUS: CSR_read_addr = MSTATUS. Write the read value with MPIE(bit7) = MIE(bit3), MIE = 0, MPP(bits12:11) = 2'b11; other bits unchanged.
- T_JUMP: CSR_read_addr = MTVEC, no write, redirect_valid = 1. redirect_pc = {mtvec[31:2], 2'b00}, or the vectored target (see Configuration). Then IDLE.

**MRET sequence**
- M_MSTATUS: read MSTATUS. Write MIE = MPIE, MPIE = 1, MPP = 2'b00.
- M_JUMP: read MEPC, redirect_pc = read data, redirect_valid = 1, then IDLE.

**Common rules**
- Outside IDLE, ex_csr_* inputs are ignored, and trap_req/mret_req are ignored; the requester must hold or re-raise them.
- stall = (state != IDLE) | trap_req | mret_req.
- All address/data arithmetic is 32-bit and wraps modulo 2^32.

## Timing
- Reset (rst=0), asynchronous:
  - state = IDLE; latched cause/pc/tval = 0.
  - Outputs forced: CSR_write_en=0, stall=0, redirect_valid=0, redirect_pc=0, CSR_write_addr=0, CSR_data_write=0, CSR_read_addr=0.
- Trap: accepted at edge 0. Writes commit at edges 1 (mepc), 2 (mcause), 3 (mtval), 4 (mstatus). redirect_valid is high during cycle 5. Back in IDLE at cycle 6, where stall drops if no new request.
- MRET: mstatus write commits at edge 1; redirect_valid is high during cycle 2; IDLE at cycle 3.
- redirect_valid is exactly one cycle wide and never asserts in IDLE.
- Reset mid-sequence: return to IDLE immediately. Writes already committed stay committed; no further writes and no redirect occur.
- Back-to-back: a trap_req held high through T_JUMP is accepted in the first IDLE cycle after it. Zero bubble besides that IDLE cycle.

## Configuration
- `CSR_VECTORED_EN` defined:
  - When mtvec[1:0] == 2'b01 and cause[31] == 1, redirect_pc = {mtvec[31:2], 2'b00} + (cause[4:0] << 2).
  - Synchronous exceptions still go to base.
- Undefined: redirect_pc is always {mtvec[31:2], 2'b00}; mtvec[1:0] is ignored.

## Test plan
- **Pass-through:** IDLE, ex_csr_we=1, waddr=0x340, wdata=0xDEADBEEF, raddr=0x305 -> CSR_write_en=1 same cycle, same addr/data, CSR_read_addr=0x305, stall=0.
- **Trap entry:**
  - Setup: mstatus=0x00000008, mtvec=0x00000100.
  - Stimulus: trap_req with cause=2, pc=0x80000046, tval=0x13, simultaneous ex_csr_we=1.
  - Response: pipeline write dropped; mepc=0x80000044, mcause=2, mtval=0x13; mstatus=0x00001880 after edge 4; redirect_valid in cycle 5 with pc=0x100; stall high cycles 0–5.
- **MRET:** mstatus=0x00001880, mepc=0x80000044, mret_req=1 -> mstatus=0x00000088 after edge 1; redirect_pc=0x80000044 in cycle 2.
- **Vectored interrupt** (`CSR_VECTORED_EN`): mtvec=0x00000101, cause=0x80000007 -> redirect_pc=0x0000011C. With macro undefined -> 0x00000100.
- **Simultaneous trap_req and mret_req** in IDLE -> trap sequence runs; no MRET mstatus write.
- **Reset mid-trap:** rst low during T_MTVAL -> mepc/mcause written, mtval/mstatus unchanged, redirect_valid never asserts, stall=0 during reset.
